cpu_run_ctrl: RTL

- Run controller directly upstream of the CPU top level.
- Owns the CPU `start` input and consumes its `halt` output.
- Sequences one program, or all programs back-to-back, and supplies the program index that selects the start address.
- Measures the execution cycles of each run and aborts any run that exceeds a timeout.

---
 rtl/cpu_run_pkg.sv | 15 +
 rtl/run_cycle_counter.sv | 31 +++
 rtl/cpu_run_ctrl.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/cpu_run_pkg.sv
// Shared types and defaults for the CPU run controller.
package cpu_run_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } run_state_t;

    localparam int          PROG_ID_W   = 2;
    localparam int          CNT_W_DEF   = 16;
    localparam logic [15:0] TIMEOUT_DEF = 16'hFFFF;

endpackage

// File: rtl/run_cycle_counter.sv
// Run-cycle counter: count includes the cycle currently enabled, so the first
// enabled cycle reads 1; terminal flags that count equals limit in that cycle.
module run_cycle_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    input  logic [CNT_W-1:0] limit,
    output logic [CNT_W-1:0] count,
    output logic             terminal
);

    logic [CNT_W-1:0] q;

    always_ff @(posedge clock) begin
        if (!reset) begin
            q <= '0;
        end else if (clear) begin
            q <= '0;
        end else if (enable) begin
            q <= q + CNT_W'(1);
        end
    end

    // q holds completed cycles; the in-progress cycle is added while enabled.
    assign count    = enable ? (q + CNT_W'(1)) : q;
    assign terminal = enable && (count == limit);

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run controller in front of the CPU: sequences programs, times each run and
// aborts on timeout. Optional per-program cycle log under CPU_RUN_PERPROG_LOG_EN.
module cpu_run_ctrl
    import cpu_run_pkg::*;
#(
    parameter int               NUM_PROGS    = 3,
    parameter int               CNT_W        = CNT_W_DEF,
    parameter logic [CNT_W-1:0] TIMEOUT      = CNT_W'(TIMEOUT_DEF),
    parameter int               START_CYCLES = 2
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 go,
    input  logic                 run_all,
    input  logic [PROG_ID_W-1:0] prog_sel,
    input  logic                 halt,
    output logic                 start,
    output logic [PROG_ID_W-1:0] prog_id,
    output logic                 busy,
    output logic                 done,
    output logic                 timeout,
    output logic [CNT_W-1:0]     cycle_count,
`ifdef CPU_RUN_PERPROG_LOG_EN
    input  logic [PROG_ID_W-1:0] rd_idx,
    output logic [CNT_W-1:0]     rd_count,
`endif
    output run_state_t           state_dbg
);

    // Handshake: go is a single-cycle request honoured only in IDLE/DONE;
    // halt is a level from the CPU, only looked at while in RUN.
    localparam int LW = (START_CYCLES > 1) ? $clog2(START_CYCLES) : 1;

    run_state_t       state, state_d;
    logic             accept_go, load_last, halt_exit, to_exit, next_prog;
    logic             run_all_q;
    logic [LW-1:0]    load_cnt;
    logic [CNT_W-1:0] run_count;
    logic             run_term;
    logic             cnt_clear, cnt_en;

    assign cnt_en    = (state == RUN);
    assign cnt_clear = (state != RUN);

    run_cycle_counter #(
        .CNT_W (CNT_W)
    ) u_run_cnt (
        .clock    (clock),
        .reset    (reset),
        .clear    (cnt_clear),
        .enable   (cnt_en),
        .limit    (TIMEOUT),
        .count    (run_count),
        .terminal (run_term)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d   = state;
        accept_go = 1'b0;
        load_last = 1'b0;
        halt_exit = 1'b0;
        to_exit   = 1'b0;
        next_prog = 1'b0;
        start     = 1'b1;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE, DONE: begin
                done = (state == DONE);
                if (go && (run_all || (32'(prog_sel) < NUM_PROGS))) begin
                    accept_go = 1'b1;
                    state_d   = LOAD;
                end
            end
            LOAD: begin
                busy = 1'b1;
                if (load_cnt == LW'(START_CYCLES - 1)) begin
                    load_last = 1'b1;
                    state_d   = RUN;
                end
            end
            RUN: begin
                start = 1'b0;
                busy  = 1'b1;
                // halt has priority over a coincident timeout
                if (halt) begin
                    halt_exit = 1'b1;
                    if (run_all_q && (32'(prog_id) < NUM_PROGS - 1)) begin
                        next_prog = 1'b1;
                        state_d   = LOAD;
                    end else begin
                        state_d = DONE;
                    end
                end else if (run_term) begin
                    to_exit = 1'b1;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            prog_id     <= '0;
            run_all_q   <= 1'b0;
            timeout     <= 1'b0;
            cycle_count <= '0;
            load_cnt    <= '0;
        end else begin
            if (accept_go) begin
                prog_id     <= run_all ? '0 : prog_sel;
                run_all_q   <= run_all;
                timeout     <= 1'b0;
                cycle_count <= '0;
            end
            if (state == LOAD) begin
                load_cnt <= load_last ? '0 : (load_cnt + LW'(1));
            end else begin
                load_cnt <= '0;
            end
            if (halt_exit) begin
                cycle_count <= run_count;
            end
            if (next_prog) begin
                prog_id <= prog_id + PROG_ID_W'(1);
            end
            if (to_exit) begin
                timeout     <= 1'b1;
                cycle_count <= TIMEOUT;
            end
        end
    end

`ifdef CPU_RUN_PERPROG_LOG_EN
    logic [CNT_W-1:0] log_q [NUM_PROGS];

    always_ff @(posedge clock) begin
        if (!reset || accept_go) begin
            for (int i = 0; i < NUM_PROGS; i++) begin
                log_q[i] <= '0;
            end
        end else if (halt_exit) begin
            log_q[prog_id] <= run_count;
        end else if (to_exit) begin
            log_q[prog_id] <= TIMEOUT;
        end
    end

    assign rd_count = (32'(rd_idx) < NUM_PROGS) ? log_q[rd_idx] : '0;
`endif

    assign state_dbg = state;

endmodule
